vgg_block_sequencer: RTL and testbench
======================================

# vgg_block_sequencer

Initiator for the convolution-block start/done protocol. Each `block_*conv` instance in the VGG16 datapath is a responder: it starts on a one-cycle `i_valid` pulse and reports completion with a one-cycle `o_valid` pulse. This block issues the start pulses to NUM_BLOCKS blocks strictly in order, waits for each block's done, and supervises the chain:

- per-block timeout
- spurious-done detection
- abort
- total cycle count

It sits at the top of the accelerator, between the host/control interface and the block chain.

## Interface

Parameters:
- NUM_BLOCKS, 5, number of chained blocks (≥1)
- TIMEOUT_CYCLES, 32'd50_000_000, max cycles to wait for one block's done (≥2)
- CNT_WIDTH, 32, width of timer and cycle counter

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  synchronous, active-low reset
- i_start  in  1  start request pulse from control
- i_abort  in  1  abort request (level, sampled each cycle)
- o_blk_start  out  NUM_BLOCKS  one-hot start pulse; bit k drives block k `i_valid`
- i_blk_done  in  NUM_BLOCKS  bit k driven by block k `o_valid`
- o_busy  out  1  high while the chain is running
- o_valid  out  1  one-cycle pulse: all blocks finished
- o_error  out  1  sticky error flag
- o_err_code  out  2  0 none, 1 timeout, 2 spurious done
- o_err_block  out  $clog2(NUM_BLOCKS) (min 1)  index of the block that failed
- o_cur_block  out  $clog2(NUM_BLOCKS) (min 1)  index of the block currently running
- o_cycles  out  CNT_WIDTH  cycles from first start pulse to final done, saturating

## Operation

- **States:** IDLE, RUN, DONE, ERR.
- **Reset:** state IDLE. All outputs are 0, including o_err_code, o_err_block, o_cur_block and o_cycles.
- **IDLE, i_start=1:**
  - Clear o_error, o_err_code, o_err_block and o_cycles.
  - Set idx=0 and pulse o_blk_start[0].
  - Go to RUN.
- **ERR, i_start=1:** same as IDLE (restart).
- **RUN:** the timer counts from 0 and o_cycles increments, saturating at all-ones.
  - **i_blk_done[idx]=1 and idx<NUM_BLOCKS-1:** idx++, pulse o_blk_start[idx+1], clear the timer.
  - **i_blk_done[idx]=1 and idx=NUM_BLOCKS-1:** go to DONE.
  - **Any other i_blk_done bit set (with or without done[idx]):** go to ERR with o_err_code=2 and o_err_block=idx.
  - **Timer reaches TIMEOUT_CYCLES-1 with no done:** go to ERR with o_err_code=1 and o_err_block=idx.
  - **Done[idx] and timeout in the same cycle:** done wins.
- **DONE:** o_valid=1 for one cycle, then IDLE. o_cycles is held until the next start.
- **ERR:** o_error=1 and stays set. o_busy=0. No start pulses are issued.
- **i_abort=1 in RUN or DONE:** go to IDLE next cycle.
  - No o_valid and no further start pulses.
  - o_error is unchanged.
  - i_abort has priority over done, timeout and i_start.
- **i_start while RUN or DONE:** ignored.
- **i_blk_done in IDLE or ERR:** ignored.
- **o_cur_block** equals idx.

## Timing

- All outputs are registered; there are no combinational input→output paths.
- **i_start → first start pulse:** i_start sampled high at edge t gives o_blk_start[0] high during cycle t+1 only.
- **done[k] → next start pulse:** done[k] sampled at edge t gives o_blk_start[k+1] high during cycle t+1. The inter-block gap is one cycle.
- **Final done → o_valid:** done[NUM_BLOCKS-1] sampled at edge t gives o_valid high during cycle t+1. o_busy falls in the same cycle.
- **o_busy:** high from cycle t+1 after a start until the cycle o_valid is asserted, inclusive of RUN only. It is 0 in DONE.
- **Timeout:** with no done, ERR is entered such that o_error rises TIMEOUT_CYCLES cycles after the start pulse cycle.
- **o_cycles** equals the number of RUN cycles, starting at 1 in the start-pulse cycle.
- **Reset:** rst_n low at any edge, including mid-RUN, gives IDLE and zeroed outputs at the next cycle. Any start pulse in flight is dropped.

## Structure

- **Package `vgg_seq_pkg`:**
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2, ERR=2'd3
  - error codes: ERR_NONE=2'd0, ERR_TIMEOUT=2'd1, ERR_SPURIOUS=2'd2
- **Sub-module `seq_timer`:** CNT_WIDTH up-counter with synchronous clear, enable, and terminal-count flag at TIMEOUT_CYCLES-1. It is instantiated once.
- **Top-level contents:** the FSM, idx register, the one-hot start decode, the saturating o_cycles counter and the error registers.

## Test plan

All scenarios use NUM_BLOCKS=3, TIMEOUT_CYCLES=20 and block models that return done after N cycles.

1. **Nominal:** i_start at cycle 0, blocks answer after 5/7/4 cycles → o_blk_start pulses at cycles 1, 7, 15; o_valid at cycle 20; o_cycles=19; o_error=0.
2. **Timeout:** block 1 never answers → o_error=1, o_err_code=1, o_err_block=1 exactly 20 cycles after block 1's start pulse; no o_blk_start[2] and no o_valid.
3. **Spurious done:** assert i_blk_done[2] while block 0 is running → ERR, o_err_code=2, o_err_block=0; then i_start → error cleared and block 0 restarted.
4. **Simultaneous done and timeout:** block 0 done arrives on timer value 19 → no error; o_blk_start[1] pulses next cycle.
5. **Abort and restart:** i_abort during block 1 → IDLE next cycle, no o_valid, o_busy=0; a following i_start runs the chain to completion. i_start pulses during RUN are ignored, with no extra start pulses.
6. **Reset mid-run:** rst_n low for 1 cycle during block 2 → all outputs 0; done arriving afterward is ignored.

Source files
------------

// File: rtl/vgg_seq_pkg.sv
// Shared types and constants for the VGG block-chain sequencer.
package vgg_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_SPURIOUS = 2'd2;

  // Index width with a floor of one bit so a single-block chain still has a port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Per-block watchdog counter with a registered terminal-count flag.
module seq_timer #(
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_WIDTH-1:0] TC_VAL = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tc_q, tc_d;

  // Flag is computed from the next count so it is valid in the cycle the count hits TC_VAL.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    tc_d = (cnt_d == TC_VAL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/vgg_block_sequencer.sv
// Start/done initiator for the chained conv blocks with timeout, spurious-done and abort supervision.
module vgg_block_sequencer
  import vgg_seq_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS     = 5,
  parameter int unsigned TIMEOUT_CYCLES = 32'd50_000_000,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_start,
  input  logic                                i_abort,
  output logic [NUM_BLOCKS-1:0]               o_blk_start,
  input  logic [NUM_BLOCKS-1:0]               i_blk_done,
  output logic                                o_busy,
  output logic                                o_valid,
  output logic                                o_error,
  output logic [1:0]                          o_err_code,
  output logic [idx_width(NUM_BLOCKS)-1:0]    o_err_block,
  output logic [idx_width(NUM_BLOCKS)-1:0]    o_cur_block,
  output logic [CNT_WIDTH-1:0]                o_cycles
);

  localparam int unsigned IDX_W = idx_width(NUM_BLOCKS);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_BLOCKS-1:0] start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;
  logic [1:0]            code_q, code_d;
  logic [IDX_W-1:0]      eblk_q, eblk_d;
  logic [CNT_WIDTH-1:0]  cycles_q, cycles_d;

  logic                  tmr_clr, tmr_en, tmr_tc;
  logic [NUM_BLOCKS-1:0] cur_mask;
  logic                  done_cur, done_other, is_last;
  logic [CNT_WIDTH-1:0]  cycles_inc;

  seq_timer #(
    .CNT_WIDTH      (CNT_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .tc_o  (tmr_tc)
  );

  assign cur_mask   = NUM_BLOCKS'(1) << idx_q;
  assign done_cur   = |(i_blk_done & cur_mask);
  assign done_other = |(i_blk_done & ~cur_mask);
  assign is_last    = (idx_q == IDX_W'(NUM_BLOCKS - 1));
  assign cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + CNT_WIDTH'(1);

  // Next-state and registered-output decode; abort outranks everything in RUN/DONE.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    start_d  = '0;
    busy_d   = 1'b0;
    valid_d  = 1'b0;
    error_d  = error_q;
    code_d   = code_q;
    eblk_d   = eblk_q;
    cycles_d = cycles_q;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;

    case (state_q)
      IDLE, ERR: begin
        if (i_start) begin
          state_d  = RUN;
          idx_d    = '0;
          start_d  = NUM_BLOCKS'(1);
          busy_d   = 1'b1;
          error_d  = 1'b0;
          code_d   = ERR_NONE;
          eblk_d   = '0;
          cycles_d = CNT_WIDTH'(1);
          tmr_clr  = 1'b1;
        end
      end
      RUN: begin
        if (i_abort) begin
          state_d = IDLE;
        end else begin
          tmr_en = 1'b1;
          if (done_other) begin
            state_d = ERR;
            error_d = 1'b1;
            code_d  = ERR_SPURIOUS;
            eblk_d  = idx_q;
          end else if (done_cur) begin
            if (is_last) begin
              state_d = DONE;
              valid_d = 1'b1;
            end else begin
              idx_d    = idx_q + IDX_W'(1);
              start_d  = NUM_BLOCKS'(1) << (idx_q + IDX_W'(1));
              busy_d   = 1'b1;
              cycles_d = cycles_inc;
              tmr_clr  = 1'b1;
            end
          end else if (tmr_tc) begin
            state_d = ERR;
            error_d = 1'b1;
            code_d  = ERR_TIMEOUT;
            eblk_d  = idx_q;
          end else begin
            busy_d   = 1'b1;
            cycles_d = cycles_inc;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      start_q  <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      code_q   <= ERR_NONE;
      eblk_q   <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      code_q   <= code_d;
      eblk_q   <= eblk_d;
      cycles_q <= cycles_d;
    end
  end

  assign o_blk_start = start_q;
  assign o_busy      = busy_q;
  assign o_valid     = valid_q;
  assign o_error     = error_q;
  assign o_err_code  = code_q;
  assign o_err_block = eblk_q;
  assign o_cur_block = idx_q;
  assign o_cycles    = cycles_q;

endmodule

// File: tb/tb_vgg_block_sequencer.sv
// Directed bench for vgg_block_sequencer: expected output events queued at stimulus time, matched by a monitor.
module tb_vgg_block_sequencer;

  localparam int unsigned NB = 3;
  localparam int unsigned TO = 20;
  localparam int unsigned CW = 32;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic [NB-1:0] i_blk_done = '0;
  logic [NB-1:0] o_blk_start;
  logic          o_busy, o_valid, o_error;
  logic [1:0]    o_err_code;
  logic [IW-1:0] o_err_block, o_cur_block;
  logic [CW-1:0] o_cycles;

  vgg_block_sequencer #(
    .NUM_BLOCKS     (NB),
    .TIMEOUT_CYCLES (TO),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .o_blk_start (o_blk_start),
    .i_blk_done  (i_blk_done),
    .o_busy      (o_busy),
    .o_valid     (o_valid),
    .o_error     (o_error),
    .o_err_code  (o_err_code),
    .o_err_block (o_err_block),
    .o_cur_block (o_cur_block),
    .o_cycles    (o_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [NB-1:0] start;
    logic          valid;
    logic          err;
    logic [1:0]    code;
    logic [IW-1:0] eblk;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  mon_ev;
  int   checks = 0;
  int   errors = 0;
  logic err_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input int c, input logic [NB-1:0] s, input logic v,
                               input logic e, input logic [1:0] cd, input logic [IW-1:0] b);
    ev_t x;
    x.cyc = c; x.start = s; x.valid = v; x.err = e; x.code = cd; x.eblk = b;
    exp_q.push_back(x);
  endfunction

  // Every start pulse, done pulse or error rise must match the head of the expectation queue.
  always @(negedge clk) begin
    if ((|o_blk_start) === 1'b1 || o_valid === 1'b1 || (o_error === 1'b1 && !err_prev)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'({o_error, o_valid, o_blk_start}), 32'd0);
      end else begin
        mon_ev = exp_q.pop_front();
        check("ev_cycle", 32'(cyc), 32'(mon_ev.cyc));
        check("ev_start", 32'(o_blk_start), 32'(mon_ev.start));
        check("ev_valid", 32'(o_valid), 32'(mon_ev.valid));
        check("ev_err", 32'({o_error, o_err_code, o_err_block}),
              32'({mon_ev.err, mon_ev.code, mon_ev.eblk}));
      end
    end
    err_prev = (o_error === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    i_start = 1'b1;
    push(cyc + 1, NB'(1), 1'b0, 1'b0, 2'd0, '0);
    tick();
    i_start = 1'b0;
  endtask

  // Block k answers n cycles after its start pulse; called in the start-pulse cycle.
  task automatic run_blk(input int k, input int n);
    repeat (n) tick();
    i_blk_done = NB'(1) << k;
    if (k < int'(NB) - 1) push(cyc + 1, NB'(1) << (k + 1), 1'b0, 1'b0, 2'd0, '0);
    else                  push(cyc + 1, '0, 1'b1, 1'b0, 2'd0, '0);
    tick();
    i_blk_done = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    @(negedge clk);
    check("rst_start", 32'(o_blk_start), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_valid_err", 32'({o_valid, o_error, o_err_code}), 32'd0);
    check("rst_blocks", 32'({o_err_block, o_cur_block}), 32'd0);
    check("rst_cycles", o_cycles, 32'd0);
    rst_n = 1'b1;
    tick();

    // Nominal: 5/7/4 cycle blocks
    go();
    run_blk(0, 5);
    run_blk(1, 7);
    run_blk(2, 4);
    @(negedge clk);
    check("nom_cycles", o_cycles, 32'd19);
    check("nom_busy", 32'(o_busy), 32'd0);
    check("nom_error", 32'(o_error), 32'd0);
    repeat (2) tick();

    // Timeout on block 1
    go();
    run_blk(0, 3);
    push(cyc + 20, '0, 1'b0, 1'b1, 2'd1, IW'(1));
    repeat (20) tick();
    @(negedge clk);
    check("to_error", 32'(o_error), 32'd1);
    check("to_code", 32'(o_err_code), 32'd1);
    check("to_block", 32'(o_err_block), 32'd1);
    check("to_busy", 32'(o_busy), 32'd0);
    check("to_cur", 32'(o_cur_block), 32'd1);
    repeat (5) tick();
    check("to_sticky", 32'(o_error), 32'd1);

    // Spurious done from block 2 while block 0 runs, then restart from ERR
    go();
    repeat (2) tick();
    i_blk_done = 3'b100;
    push(cyc + 1, '0, 1'b0, 1'b1, 2'd2, IW'(0));
    tick();
    i_blk_done = '0;
    @(negedge clk);
    check("sp_code", 32'(o_err_code), 32'd2);
    check("sp_block", 32'(o_err_block), 32'd0);
    check("sp_busy", 32'(o_busy), 32'd0);
    tick();
    go();
    @(negedge clk);
    check("sp_restart_err", 32'({o_error, o_err_code}), 32'd0);
    check("sp_restart_cyc", o_cycles, 32'd1);
    run_blk(0, 2);
    run_blk(1, 2);
    run_blk(2, 2);
    repeat (2) tick();

    // Done on the terminal timer value wins over timeout
    go();
    run_blk(0, 19);
    @(negedge clk);
    check("tie_error", 32'(o_error), 32'd0);
    check("tie_cur", 32'(o_cur_block), 32'd1);
    run_blk(1, 2);
    run_blk(2, 2);
    repeat (2) tick();

    // Abort during block 1 with ignored start requests, then full run
    go();
    run_blk(0, 3);
    tick();
    i_start = 1'b1;
    repeat (2) tick();
    i_start = 1'b0;
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    @(negedge clk);
    check("ab_busy", 32'(o_busy), 32'd0);
    check("ab_outs", 32'({o_valid, o_blk_start}), 32'd0);
    repeat (3) tick();
    go();
    run_blk(0, 2);
    run_blk(1, 3);
    run_blk(2, 2);
    @(negedge clk);
    check("ab_cycles", o_cycles, 32'd10);
    repeat (2) tick();

    // Reset during block 2; a late done must be ignored
    go();
    run_blk(0, 2);
    run_blk(1, 2);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_busy", 32'(o_busy), 32'd0);
    check("mr_start", 32'(o_blk_start), 32'd0);
    check("mr_cur", 32'(o_cur_block), 32'd0);
    check("mr_cycles", o_cycles, 32'd0);
    i_blk_done = 3'b100;
    tick();
    i_blk_done = '0;
    tick();
    @(negedge clk);
    check("mr_idle", 32'({o_busy, o_valid, o_error}), 32'd0);
    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
